pipe_stage_skid: RTL

//  Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a 2-entry skid buffer (main + skid slot) and a registered in_ready.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 198,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register: the valid pair is the state encoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_ctrl_q  <= skid_ctrl_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  // Next state; inputs are only sampled on in_fire so an idle bus cannot leak X into ctrl.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_ctrl_d  = main_ctrl_q;
    skid_ctrl_d  = skid_ctrl_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_ctrl_d  = '0;
      main_data_d  = '0;
      skid_data_d  = '0;
    end else begin
      unique case ({main_valid_q, skid_valid_q})
        2'b00: if (in_fire) begin
          main_valid_d = 1'b1;
          main_ctrl_d  = in_ctrl;
          main_data_d  = in_data;
        end
        2'b10: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
          end else if (out_fire) begin
            main_valid_d = 1'b0;
          end
        end
        2'b11: if (out_fire) begin
          main_ctrl_d  = skid_ctrl_q;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
          skid_ctrl_d  = '0;
          skid_data_d  = '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs: a bubble never presents nonzero control.
  always_comb begin
    in_ready  = ~skid_valid_q;
    out_valid = main_valid_q;
    out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    out_data  = main_data_q;
    occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && (occupancy != 2'd0 || in_valid) && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
